// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, state encoding and datapath select codes
// for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS control FSM with memory-ready
// stalls and optional ADDI/J support.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state, nextState, decodeNext;
    logic   isStore;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            isStore <= 1'b0;
        end else begin
            if (state == DECODE) isStore <= (opcode == OP_SW);
            state <= nextState;
        end
    end

    // Unsupported opcodes fall back to FETCH, which is also how illegal_op is detected.
    always_comb begin
        case (opcode)
            OP_RTYPE:     decodeNext = EXECUTE;
            OP_LW, OP_SW: decodeNext = MEMADR;
            OP_BEQ:       decodeNext = BRANCH;
            OP_ADDI:      decodeNext = ENABLE_ADDI ? ADDIEX : FETCH;
            OP_J:         decodeNext = ENABLE_J ? JUMP : FETCH;
            default:      decodeNext = FETCH;
        endcase
    end

    always_comb begin
        case (state)
            FETCH:   nextState = mem_ready ? DECODE : FETCH;
            DECODE:  nextState = decodeNext;
            MEMADR:  nextState = isStore ? MEMWR : MEMRD;
            MEMRD:   nextState = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nextState = mem_ready ? FETCH : MEMWR;
            EXECUTE: nextState = ALUWB;
            ADDIEX:  nextState = ADDIWB;
            default: nextState = FETCH;
        endcase
    end

    // Everything is gated by rst_n so reset forces strobes and selects low immediately.
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = PC_ALU;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALU_ADD;
        illegal_op = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB    = SRCB_IMMSH;
                    illegal_op = (decodeNext == FETCH);
                end
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_SUB;
                    PCSrc   = PC_ALUOUT;
                    Branch  = 1'b1;
                end
                ADDIWB: RegWrite = 1'b1;
                JUMP: begin
                    PCSrc   = PC_JUMP;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control FSM for the multi-cycle MIPS datapath, successor to the single-cycle combinational control block. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath's mux selects and write strobes. Adds two features: a memory-ready handshake so fetch and data accesses can stall, and parameter-selectable support for ADDI and J.

## Interface
- ENABLE_ADDI, 1: when 1, opcode 001000 (ADDI) is executed; when 0, it is treated as illegal.
- ENABLE_J, 1: when 1, opcode 000010 (J) is executed; when 0, it is treated as illegal.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE only.
- mem_ready  in  1  memory access complete this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load, qualified by Zero in the datapath.
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- RegDst  out  1  write-register select: 0 = rt, 1 = rd.
- MemToReg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and recover to FETCH.
- Outputs are a Moore decode of the state, except IRWrite/PCWrite in FETCH, which are Mealy on mem_ready.
- Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready, otherwise holds.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 000000 → EXECUTE
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 001000 → ADDIEX (only if ENABLE_ADDI)
    - 000010 → JUMP (only if ENABLE_J)
    - any other → FETCH with illegal_op=1
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW.
  - MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready, otherwise holds.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Goes to FETCH.
  - MEMWR: MemWrite=1, IorD=1. Goes to FETCH on mem_ready, otherwise holds.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Goes to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Goes to FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- The opcode for MEMADR's branch is the value latched in DECODE; MEMADR does not re-sample opcode.

## Timing
- Reset (rst_n=0):
  - State goes to FETCH immediately (asynchronous).
  - All strobes are forced 0 combinationally: MemRead, MemWrite, IRWrite, PCWrite, Branch, RegWrite, illegal_op.
  - All selects read 0; state_o=0.
- The first FETCH cycle is the first rising edge after rst_n deasserts.
- Cycles per instruction with mem_ready held at 1:

| Instruction | Cycles |
|---|---|
| R-type | 4 |
| LW | 5 |
| SW | 4 |
| BEQ | 3 |
| ADDI | 4 |
| J | 3 |

- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold stable while stalled.
- mem_ready is ignored in all other states.
- Reset asserted mid-instruction (including during a stall) aborts it. No partial write strobe may follow reset release.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the state encoding constants;
  - ALUOp and PCSrc/ALUSrcB code constants.
- This is a single module: a state register, a next-state process and an output decode. No sub-module is needed.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 → all strobes 0 and state_o=0. Release → FETCH with IRWrite=PCWrite=1 on the first cycle.
- LW (100011), mem_ready=1 → states 0,1,2,3,4, then 0. RegWrite=1 and MemToReg=1 only in cycle 5.
- SW with mem_ready low for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles, then return to FETCH.
- FETCH stall of 2 cycles then R-type → IRWrite=0 during the stall. It pulses exactly once, then the sequence runs EXECUTE (ALUOp=10) and ALUWB (RegDst=1).
- BEQ → 3 cycles; Branch=1, PCSrc=01 and ALUOp=01 in BRANCH only.
- ENABLE_J=0 with opcode 000010, and opcode 111111 → illegal_op pulses 1 cycle in DECODE, the next state is FETCH, and no write strobe is asserted.
